prom_loader: RTL and testbench
==============================

Name: prom_loader

Overview:
- Writer side of the cpu15 program ROM.
- Accepts a byte stream from a host link with a valid/ready handshake, assembles 15-bit instructions, and writes them into a 256 x 15 program memory.
- The fetch stage reads the same memory through P_COUNT/PROM_OUT.
- Holds the CPU in reset (CPU_RESET_N low) until a complete image has loaded without error.

Parameters:
- ADDR_W, 8: program memory address width; depth is 2**ADDR_W words.
- WORD_W, 15: instruction width; matches the fetch PROM_OUT width.

Ports:
- CLK  input  1  system clock; all state changes on its rising edge
- RESET_N  input  1  asynchronous, active-low reset
- LOAD_START  input  1  single-cycle request to begin loading an image
- RX_DATA  input  8  byte from the host link
- RX_VALID  input  1  RX_DATA is valid
- RX_READY  output  1  loader will accept RX_DATA this cycle
- P_COUNT  input  ADDR_W  fetch address from the exec stage
- PROM_OUT  output  WORD_W  instruction word to fetch
- CPU_RESET_N  output  1  active-low reset to the cpu15 core
- LOAD_BUSY  output  1  load in progress
- LOAD_ERR  output  1  sticky: last load aborted
- LOAD_COUNT  output  ADDR_W+1  number of words written by the current or last load

Behaviour:
- Reset values:
  - RX_READY=0, CPU_RESET_N=0, LOAD_BUSY=0, LOAD_ERR=0, LOAD_COUNT=0, PROM_OUT=0, state=IDLE.
  - Memory array is not reset.
- Byte transfer occurs only on a rising edge with RX_VALID=1 and RX_READY=1. RX_READY=1 exactly in states LEN, HI and LO.
- Image format:
  - 1 length byte L; L=0 means 256 words.
  - Then per word, a high byte followed by a low byte: word = {hi[6:0], lo[7:0]}.
- FSM states: IDLE, LEN, HI, LO.
  - IDLE: on LOAD_START=1, go to LEN next cycle. On that same edge: LOAD_BUSY<=1, CPU_RESET_N<=0, LOAD_ERR<=0, LOAD_COUNT<=0, write pointer<=0.
  - LEN: on transfer, latch the target count (L, or 256 when L=0) and go to HI.
  - HI: on transfer with RX_DATA[7]=0, latch hi and go to LO.
  - HI error: on transfer with RX_DATA[7]=1, set LOAD_ERR<=1 and LOAD_BUSY<=0, keep CPU_RESET_N=0, go to IDLE. No memory write occurs.
  - LO: on transfer, write mem[ptr] <= {hi[6:0], RX_DATA}, ptr++, LOAD_COUNT++.
  - LO, not last word: if the new LOAD_COUNT is below the target, go to HI.
  - LO, last word: otherwise go to IDLE with LOAD_BUSY<=0 and CPU_RESET_N<=1. The CPU comes out of reset on the cycle after the last write.
- LOAD_START outside IDLE is ignored. No abort-by-restart.
- Stalls: RX_VALID=0 in any active state holds the state indefinitely. No timeout.
- Pointer wrap: the 256-word image ends with ptr wrapping to 0. LOAD_COUNT is 9 bits, so it reads 256.
- Words beyond the loaded count keep their previous contents.
- Read port:
  - PROM_OUT <= mem[P_COUNT] on every rising edge (1-cycle latency) while LOAD_BUSY=0.
  - PROM_OUT <= 0 while LOAD_BUSY=1.
- Read/write to the same address in one cycle cannot occur, because reads are blanked during load.
- RESET_N asserted mid-load:
  - Returns immediately to the reset values and IDLE; CPU_RESET_N=0.
  - Memory keeps whatever was partially written.
  - A new LOAD_START is required before the CPU runs.

Test Plan:
- Basic load: after reset, LOAD_START, then bytes 02,12,34,7F,FF with RX_VALID held 1 -> mem[0]=0x1234, mem[1]=0x7FFF. LOAD_COUNT=2. CPU_RESET_N rises 1 cycle after the 5th byte. P_COUNT=1 gives PROM_OUT=0x7FFF one cycle later.
- Backpressure/stall: the same image with RX_VALID toggled 1/0 every cycle -> identical memory contents; RX_READY stays 1 during the gaps; the state does not advance on RX_VALID=0 cycles.
- Error path: LOAD_START, bytes 03,12,34,80 -> LOAD_ERR=1, LOAD_BUSY=0, CPU_RESET_N=0, LOAD_COUNT=1, mem[1] unchanged. A subsequent good load clears LOAD_ERR.
- Full image: L=00 followed by 512 bytes with word i = i -> LOAD_COUNT=256; mem[255]=0x00FF; PROM_OUT correct for P_COUNT=0 and 255.
- Mid-load reset: pulse RESET_N low after the 3rd byte -> all outputs at reset values immediately. LOAD_START during a later busy load has no effect on count or state.

Source files
------------

// File: rtl/prom_loader.sv
// Program ROM writer for cpu15: assembles 15-bit words from a host byte stream
// into a 256 x 15 memory and holds the core in reset until an image loads cleanly.
module prom_loader #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned WORD_W = 15
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              LOAD_START,
    input  logic [7:0]        RX_DATA,
    input  logic              RX_VALID,
    output logic              RX_READY,
    input  logic [ADDR_W-1:0] P_COUNT,
    output logic [WORD_W-1:0] PROM_OUT,
    output logic              CPU_RESET_N,
    output logic              LOAD_BUSY,
    output logic              LOAD_ERR,
    output logic [ADDR_W:0]   LOAD_COUNT
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned HI_W  = WORD_W - 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LEN  = 2'd1,
        HI   = 2'd2,
        LO   = 2'd3
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] ptr, ptr_n;
    logic [CNT_W-1:0]  target, target_n;
    logic [CNT_W-1:0]  count_n;
    logic [HI_W-1:0]   hi_q, hi_n;
    logic              busy_n, err_n, cpu_n, ready_n;
    logic              xfer, wr_en;

    logic [WORD_W-1:0] mem [DEPTH];

    assign xfer = RX_VALID && RX_READY;

    // Next-state and register-update logic
    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        target_n = target;
        count_n  = LOAD_COUNT;
        hi_n     = hi_q;
        busy_n   = LOAD_BUSY;
        err_n    = LOAD_ERR;
        cpu_n    = CPU_RESET_N;
        wr_en    = 1'b0;

        case (state)
            IDLE: begin
                if (LOAD_START) begin
                    state_n = LEN;
                    busy_n  = 1'b1;
                    cpu_n   = 1'b0;
                    err_n   = 1'b0;
                    count_n = '0;
                    ptr_n   = '0;
                end
            end
            LEN: begin
                if (xfer) begin
                    // A zero length byte encodes a full-depth image
                    target_n = (RX_DATA == 8'd0) ? CNT_W'(DEPTH) : CNT_W'(RX_DATA);
                    state_n  = HI;
                end
            end
            HI: begin
                if (xfer) begin
                    if (RX_DATA[7]) begin
                        err_n   = 1'b1;
                        busy_n  = 1'b0;
                        cpu_n   = 1'b0;
                        state_n = IDLE;
                    end else begin
                        hi_n    = RX_DATA[HI_W-1:0];
                        state_n = LO;
                    end
                end
            end
            LO: begin
                if (xfer) begin
                    wr_en   = 1'b1;
                    ptr_n   = ptr + ADDR_W'(1);
                    count_n = LOAD_COUNT + CNT_W'(1);
                    if (count_n < target) begin
                        state_n = HI;
                    end else begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                        cpu_n   = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        ready_n = (state_n != IDLE);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= IDLE;
            ptr         <= '0;
            target      <= '0;
            hi_q        <= '0;
            LOAD_COUNT  <= '0;
            LOAD_BUSY   <= 1'b0;
            LOAD_ERR    <= 1'b0;
            CPU_RESET_N <= 1'b0;
            RX_READY    <= 1'b0;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            target      <= target_n;
            hi_q        <= hi_n;
            LOAD_COUNT  <= count_n;
            LOAD_BUSY   <= busy_n;
            LOAD_ERR    <= err_n;
            CPU_RESET_N <= cpu_n;
            RX_READY    <= ready_n;
        end
    end

    // Memory array is deliberately not reset
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[ptr] <= {hi_q, RX_DATA};
        end
    end

    // Fetch port is blanked while loading, so it never collides with a write
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            PROM_OUT <= '0;
        end else if (LOAD_BUSY) begin
            PROM_OUT <= '0;
        end else begin
            PROM_OUT <= mem[P_COUNT];
        end
    end

endmodule

// File: tb/tb_prom_loader.sv
// Bench for prom_loader: directed image loads plus randomized images with stalls
// and error injection, checked against a word-level image model.
module tb_prom_loader;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned WORD_W = 15;
    localparam int unsigned DEPTH  = 256;

    logic              CLK = 1'b0;
    logic              RESET_N = 1'b0;
    logic              LOAD_START = 1'b0;
    logic [7:0]        RX_DATA = 8'h00;
    logic              RX_VALID = 1'b0;
    logic [ADDR_W-1:0] P_COUNT = '0;
    logic              RX_READY;
    logic [WORD_W-1:0] PROM_OUT;
    logic              CPU_RESET_N;
    logic              LOAD_BUSY;
    logic              LOAD_ERR;
    logic [ADDR_W:0]   LOAD_COUNT;

    int n_assert = 0;
    int n_fail   = 0;

    logic [WORD_W-1:0] ref_mem   [DEPTH];
    bit                ref_known [DEPTH];
    logic [WORD_W-1:0] img       [DEPTH];

    prom_loader #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .LOAD_START  (LOAD_START),
        .RX_DATA     (RX_DATA),
        .RX_VALID    (RX_VALID),
        .RX_READY    (RX_READY),
        .P_COUNT     (P_COUNT),
        .PROM_OUT    (PROM_OUT),
        .CPU_RESET_N (CPU_RESET_N),
        .LOAD_BUSY   (LOAD_BUSY),
        .LOAD_ERR    (LOAD_ERR),
        .LOAD_COUNT  (LOAD_COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_ready"}, RX_READY, 0);
        chk({tag, "_cpu"},   CPU_RESET_N, 0);
        chk({tag, "_busy"},  LOAD_BUSY, 0);
        chk({tag, "_err"},   LOAD_ERR, 0);
        chk({tag, "_count"}, LOAD_COUNT, 0);
        chk({tag, "_prom"},  PROM_OUT, 0);
    endtask

    task automatic start_load();
        LOAD_START = 1'b1;
        tick();
        LOAD_START = 1'b0;
        chk("start_busy",  LOAD_BUSY, 1);
        chk("start_ready", RX_READY, 1);
        chk("start_count", LOAD_COUNT, 0);
        chk("start_cpu",   CPU_RESET_N, 0);
        chk("start_err",   LOAD_ERR, 0);
    endtask

    // Idle for gap cycles (checking the loader holds), then hand over one byte
    task automatic send_byte(input logic [7:0] b, input int gap);
        logic [ADDR_W:0] held;
        int k;
        for (int g = 0; g < gap; g++) begin
            RX_VALID = 1'b0;
            RX_DATA  = 8'($urandom);
            held     = LOAD_COUNT;
            tick();
            chk("stall_ready", RX_READY, 1);
            chk("stall_count", LOAD_COUNT, held);
            chk("stall_blank", PROM_OUT, 0);
        end
        RX_DATA  = b;
        RX_VALID = 1'b1;
        k = 0;
        while (!RX_READY && k < 20) begin
            tick();
            k++;
        end
        if (!RX_READY) begin
            chk("byte_accept_timeout", 0, 1);
        end else begin
            tick();
        end
        RX_VALID = 1'b0;
    endtask

    // Sweep the read port over every word whose contents the model knows
    task automatic check_mem(input string tag);
        for (int a = 0; a < int'(DEPTH); a++) begin
            if (ref_known[a]) begin
                P_COUNT = ADDR_W'(a);
                tick();
                chk($sformatf("%s_mem[%0d]", tag, a), PROM_OUT, ref_mem[a]);
            end
        end
    endtask

    // Send an n-word image from img[]; err_idx >= 0 corrupts that word's high byte
    task automatic load_image(input string tag, input int n, input int err_idx,
                              input int gap_min, input int gap_max);
        logic [7:0] q[$];
        int exp_count;
        bit good;
        q.push_back(8'(n % 256));
        for (int i = 0; i < n; i++) begin
            if (i == err_idx) begin
                q.push_back({1'b1, img[i][14:8]});
                break;
            end
            q.push_back({1'b0, img[i][14:8]});
            q.push_back(img[i][7:0]);
        end
        start_load();
        for (int j = 0; j < q.size(); j++) begin
            send_byte(q[j], int'($urandom_range(gap_max, gap_min)));
            if (j < q.size() - 1) begin
                chk({tag, "_cpu_held"}, CPU_RESET_N, 0);
                chk({tag, "_busy_mid"}, LOAD_BUSY, 1);
            end
        end
        good      = (err_idx < 0);
        exp_count = good ? n : err_idx;
        chk({tag, "_busy_end"},  LOAD_BUSY, 0);
        chk({tag, "_ready_end"}, RX_READY, 0);
        chk({tag, "_err"},       LOAD_ERR, good ? 0 : 1);
        chk({tag, "_cpu"},       CPU_RESET_N, good ? 1 : 0);
        chk({tag, "_count"},     LOAD_COUNT, exp_count);
        for (int i = 0; i < exp_count; i++) begin
            ref_mem[i]   = img[i];
            ref_known[i] = 1'b1;
        end
        check_mem(tag);
    endtask

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) ref_known[i] = 1'b0;

        // Reset values while held in reset
        #12;
        chk_reset_values("reset");
        RESET_N = 1'b1;
        tick();
        tick();
        chk_reset_values("post_reset");

        // Basic two-word load
        img[0] = 15'h1234;
        img[1] = 15'h7FFF;
        load_image("basic", 2, -1, 0, 0);
        P_COUNT = 8'd1;
        tick();
        chk("basic_pcount1", PROM_OUT, 15'h7FFF);

        // Same image with valid toggling every cycle
        load_image("stall", 2, -1, 1, 1);

        // Bad high byte on word 1: mem[1] must keep 0x7FFF
        img[0] = 15'h1234;
        img[1] = 15'h0000;
        img[2] = 15'h0000;
        load_image("error", 3, 1, 0, 0);
        chk("error_mem1_direct", ref_mem[1] == 15'h7FFF ? 1 : 0, 1);

        // A following good load clears LOAD_ERR
        for (int i = 0; i < 4; i++) img[i] = WORD_W'($urandom);
        load_image("recover", 4, -1, 0, 1);

        // Full 256-word image, word i = i
        for (int i = 0; i < int'(DEPTH); i++) img[i] = WORD_W'(i);
        load_image("full", 256, -1, 0, 0);
        P_COUNT = 8'd255;
        tick();
        chk("full_pcount255", PROM_OUT, 15'h00FF);
        P_COUNT = 8'd0;
        tick();
        chk("full_pcount0", PROM_OUT, 15'h0000);

        // Asynchronous reset after the third byte (first word already written)
        img[0] = 15'h2ABC;
        start_load();
        send_byte(8'd5, 0);
        send_byte({1'b0, img[0][14:8]}, 0);
        send_byte(img[0][7:0], 0);
        chk("midreset_count_before", LOAD_COUNT, 1);
        #2;
        RESET_N = 1'b0;
        #1;
        chk_reset_values("midreset");
        ref_mem[0] = img[0];
        #3;
        RESET_N = 1'b1;
        tick();
        tick();
        chk("midreset_cpu_stays", CPU_RESET_N, 0);
        chk("midreset_busy_stays", LOAD_BUSY, 0);
        check_mem("midreset");

        // LOAD_START while busy must not restart the load
        img[0] = 15'h0155;
        img[1] = 15'h7A0F;
        start_load();
        send_byte(8'd2, 0);
        send_byte({1'b0, img[0][14:8]}, 0);
        LOAD_START = 1'b1;
        tick();
        LOAD_START = 1'b0;
        chk("restart_busy",  LOAD_BUSY, 1);
        chk("restart_ready", RX_READY, 1);
        chk("restart_count", LOAD_COUNT, 0);
        send_byte(img[0][7:0], 0);
        chk("restart_count1", LOAD_COUNT, 1);
        send_byte({1'b0, img[1][14:8]}, 0);
        send_byte(img[1][7:0], 0);
        chk("restart_count2", LOAD_COUNT, 2);
        chk("restart_cpu",    CPU_RESET_N, 1);
        ref_mem[0] = img[0];
        ref_mem[1] = img[1];
        ref_known[0] = 1'b1;
        ref_known[1] = 1'b1;
        check_mem("restart");

        // Randomized images with random stalls and occasional corruption
        for (int it = 0; it < 8; it++) begin
            int n;
            int e;
            n = int'($urandom_range(24, 1));
            for (int i = 0; i < n; i++) img[i] = WORD_W'($urandom);
            e = ($urandom_range(3, 0) == 0) ? int'($urandom_range(n - 1, 0)) : -1;
            load_image($sformatf("rand%0d", it), n, e, 0, 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
